// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin arbiter sharing one downstream APB bus among several masters
module apb_rr_arbiter #(
  parameter int BUS_WIDTH = 16,
  parameter int MASTER_PORTS = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic                              M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  output logic [MASTER_PORTS-1:0]           GRANT,
  output logic                              TIMEOUT_ERR
);
  localparam int LW = $clog2(MASTER_PORTS);
  localparam int TC1 = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CW = TC1 > 0 ? $clog2(TC1 + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, next;
  logic [LW-1:0] last, owner, pick;
  logic [CW-1:0] cnt;
  logic found, to, done;
  int idx;
  logic unused;
  assign unused = ^S_PENABLE;
  // first requester above the last owner, wrapping around
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      idx = (int'(last) + k) % MASTER_PORTS;
      if (!found && S_PSELx[idx]) begin
        pick = LW'(idx);
        found = 1'b1;
      end
    end
  end
  // completion (slave ready or watchdog expiry) and routing back to the owner only
  always_comb begin
    to = TIMEOUT_CYCLES > 0 && state == ACCESS && !M_PREADY && cnt == CW'(TC1);
    done = state == ACCESS && (M_PREADY || to);
    S_PREADY = (done && !reset) ? GRANT : '0;
    S_PRDATA = '0;
    for (int i = 0; i < MASTER_PORTS; i++)
      S_PRDATA[i*BUS_WIDTH +: BUS_WIDTH] = (S_PREADY[i] && !to) ? M_PRDATA : '0;
  end
  // next-state: IDLE -> SETUP -> ACCESS -> IDLE
  always_comb begin
    next = state;
    next = state == IDLE ? (found ? SETUP : IDLE) : state == SETUP ? ACCESS : done ? IDLE : ACCESS;
  end
  assign M_PSELx = state != IDLE;
  assign M_PENABLE = state == ACCESS;
  // state, captured downstream request, grant, pointer and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= LW'(MASTER_PORTS - 1);
      owner <= '0;
      M_PADDR <= '0;
      M_PWDATA <= '0;
      M_PWRITE <= 1'b0;
      GRANT <= '0;
      cnt <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state <= next;
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        M_PADDR <= S_PADDR[pick*BUS_WIDTH +: BUS_WIDTH];
        M_PWDATA <= S_PWDATA[pick*BUS_WIDTH +: BUS_WIDTH];
        M_PWRITE <= S_PWRITE[pick];
        GRANT <= MASTER_PORTS'(1) << pick;
        owner <= pick;
      end
      if (done) begin
        last <= owner;
        GRANT <= '0;
      end
      if (to) TIMEOUT_ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: randomized and directed checks against a transaction-level round-robin model
module tb_apb_rr_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic [63:0] S_PADDR = 0, S_PWDATA = 0, S_PRDATA;
  logic [3:0] S_PWRITE = 0, S_PSELx = 0, S_PENABLE = 0, S_PREADY, GRANT;
  logic [15:0] M_PADDR, M_PWDATA, M_PRDATA = 0;
  logic M_PWRITE, M_PSELx, M_PENABLE, M_PREADY = 0, TIMEOUT_ERR;
  logic w_reset = 1, w_ready = 0;
  logic [3:0] w_sel = 0, w_spready, w_grant;
  logic [63:0] w_sprdata;
  logic [15:0] w_paddr, w_pwdata, w_rdata = 0;
  logic w_pwrite, w_psel, w_penable, w_err;
  int checks = 0, failures = 0, last_m = 3;

  always #5 clk = ~clk;

  apb_rr_arbiter dut (.clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .M_PADDR(M_PADDR),
    .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR));

  apb_rr_arbiter #(.TIMEOUT_CYCLES(8)) wdt (.clk(clk), .reset(w_reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
    .S_PSELx(w_sel), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(w_sprdata), .S_PREADY(w_spready),
    .M_PADDR(w_paddr), .M_PWRITE(w_pwrite), .M_PSELx(w_psel), .M_PENABLE(w_penable), .M_PWDATA(w_pwdata),
    .M_PRDATA(w_rdata), .M_PREADY(w_ready), .GRANT(w_grant), .TIMEOUT_ERR(w_err));

  function automatic int rr_pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    S_PSELx = 0;
    M_PREADY = 0;
    @(negedge clk);
    reset = 0;
    last_m = 3;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({M_PADDR, M_PWDATA, M_PWRITE, M_PSELx, M_PENABLE, GRANT, S_PREADY, S_PRDATA, TIMEOUT_ERR} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got paddr=%h pwdata=%h wr=%b sel=%b en=%b grant=%b rdy=%b rdata=%h err=%b want all zero",
        M_PADDR, M_PWDATA, M_PWRITE, M_PSELx, M_PENABLE, GRANT, S_PREADY, S_PRDATA, TIMEOUT_ERR);
    end
  endtask

  // one full transfer starting in an IDLE cycle; ends in the following IDLE cycle
  task automatic run_xfer(input logic [3:0] mask, input int w, input logic [15:0] rdv, input logic fixed, output int g);
    logic [15:0] addr[4], wd[4], rd;
    logic [3:0] wr;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 16'($urandom);
      wd[i] = 16'($urandom);
      S_PADDR[i*16 +: 16] = addr[i];
      S_PWDATA[i*16 +: 16] = wd[i];
    end
    wr = 4'($urandom);
    S_PWRITE = wr;
    S_PSELx = mask;
    M_PREADY = 0;
    g = rr_pick(mask, last_m);
    #1;
    checks++;
    if (GRANT !== 4'b0 || M_PSELx !== 1'b0) begin
      failures++;
      $display("FAIL idle_state got grant=%b sel=%b want 0000 0", GRANT, M_PSELx);
    end
    @(negedge clk);
    S_PSELx = 4'($urandom);
    S_PADDR = {$urandom, $urandom};
    #1;
    checks++;
    if (GRANT !== 4'(1 << g) || M_PSELx !== 1'b1 || M_PENABLE !== 1'b0 || S_PREADY !== 4'b0) begin
      failures++;
      $display("FAIL setup_phase got grant=%b sel=%b en=%b rdy=%b want grant=%b sel=1 en=0 rdy=0000",
        GRANT, M_PSELx, M_PENABLE, S_PREADY, 4'(1 << g));
    end
    checks++;
    if (M_PADDR !== addr[g] || M_PWDATA !== wd[g] || M_PWRITE !== wr[g]) begin
      failures++;
      $display("FAIL setup_capture got addr=%h data=%h wr=%b want addr=%h data=%h wr=%b",
        M_PADDR, M_PWDATA, M_PWRITE, addr[g], wd[g], wr[g]);
    end
    for (int j = 0; j <= w; j++) begin
      @(negedge clk);
      M_PREADY = (j == w);
      rd = fixed ? rdv : 16'($urandom);
      M_PRDATA = rd;
      S_PSELx = 4'($urandom);
      #1;
      checks++;
      if (M_PENABLE !== 1'b1 || M_PSELx !== 1'b1 || M_PADDR !== addr[g] || M_PWDATA !== wd[g]) begin
        failures++;
        $display("FAIL access_phase cycle %0d got en=%b sel=%b addr=%h data=%h want en=1 sel=1 addr=%h data=%h",
          j, M_PENABLE, M_PSELx, M_PADDR, M_PWDATA, addr[g], wd[g]);
      end
      checks++;
      if (S_PREADY !== (j == w ? 4'(1 << g) : 4'b0) || S_PRDATA !== (j == w ? 64'(rd) << (g * 16) : 64'b0)) begin
        failures++;
        $display("FAIL access_return cycle %0d got rdy=%b rdata=%h want rdy=%b rdata=%h", j, S_PREADY, S_PRDATA,
          (j == w ? 4'(1 << g) : 4'b0), (j == w ? 64'(rd) << (g * 16) : 64'b0));
      end
    end
    @(negedge clk);
    M_PREADY = 0;
    S_PSELx = 0;
    #1;
    checks++;
    if (M_PSELx !== 1'b0 || M_PENABLE !== 1'b0 || GRANT !== 4'b0 || S_PREADY !== 4'b0) begin
      failures++;
      $display("FAIL back_to_idle got sel=%b en=%b grant=%b rdy=%b want 0 0 0000 0000", M_PSELx, M_PENABLE, GRANT, S_PREADY);
    end
    last_m = g;
  endtask

  task automatic test_single_write();
    do_reset();
    S_PADDR = 0;
    S_PWDATA = 0;
    S_PADDR[16 +: 16] = 16'h0081;
    S_PWDATA[16 +: 16] = 16'h1234;
    S_PWRITE = 4'b0010;
    S_PSELx = 4'b0010;
    M_PREADY = 1;
    @(negedge clk);
    #1;
    checks++;
    if (M_PADDR !== 16'h0081 || M_PSELx !== 1'b1 || M_PWDATA !== 16'h1234 || M_PWRITE !== 1'b1) begin
      failures++;
      $display("FAIL single_setup got addr=%h sel=%b data=%h wr=%b want 0081 1 1234 1", M_PADDR, M_PSELx, M_PWDATA, M_PWRITE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (M_PENABLE !== 1'b1 || S_PREADY !== 4'b0010) begin
      failures++;
      $display("FAIL single_access got en=%b rdy=%b want 1 0010", M_PENABLE, S_PREADY);
    end
    S_PSELx = 0;
    @(negedge clk);
    M_PREADY = 0;
    #1;
    checks++;
    if (M_PSELx !== 1'b0 || S_PREADY !== 4'b0) begin
      failures++;
      $display("FAIL single_idle got sel=%b rdy=%b want 0 0000", M_PSELx, S_PREADY);
    end
  endtask

  task automatic test_full_contention();
    logic [3:0] exp;
    do_reset();
    S_PSELx = 4'b1111;
    M_PREADY = 1;
    for (int c = 0; c < 18; c++) begin
      exp = (c % 3 == 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
      #1;
      checks++;
      if (S_PREADY !== exp) begin
        failures++;
        $display("FAIL full_contention cycle %0d got rdy=%b want %b", c, S_PREADY, exp);
      end
      @(negedge clk);
    end
    S_PSELx = 0;
    M_PREADY = 0;
    do_reset();
  endtask

  task automatic test_partial_contention();
    int g;
    do_reset();
    run_xfer(4'b0001, 0, 16'h0, 1'b0, g);
    for (int n = 0; n < 4; n++) begin
      run_xfer(4'b0101, $urandom_range(0, 2), 16'h0, 1'b0, g);
      checks++;
      if (g !== (n % 2 == 0 ? 2 : 0)) begin
        failures++;
        $display("FAIL partial_order step %0d got master %0d want %0d", n, g, (n % 2 == 0 ? 2 : 0));
      end
    end
  endtask

  task automatic test_wait_states();
    int g;
    do_reset();
    run_xfer(4'b1000, 3, 16'hBEEF, 1'b1, g);
    checks++;
    if (g !== 3) begin
      failures++;
      $display("FAIL wait_grant got master %0d want 3", g);
    end
  endtask

  task automatic test_reset_in_access();
    int g;
    do_reset();
    S_PSELx = 4'b0100;
    S_PWRITE = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    M_PREADY = 1;
    M_PRDATA = 16'hA5A5;
    reset = 1;
    #1;
    checks++;
    if (S_PREADY !== 4'b0 || GRANT !== 4'b0100) begin
      failures++;
      $display("FAIL reset_access_pulse got rdy=%b grant=%b want 0000 0100", S_PREADY, GRANT);
    end
    @(negedge clk);
    reset = 0;
    M_PREADY = 0;
    S_PSELx = 0;
    last_m = 3;
    #1;
    checks++;
    if ({M_PADDR, M_PWDATA, M_PWRITE, M_PSELx, M_PENABLE, GRANT, S_PREADY, S_PRDATA} !== '0) begin
      failures++;
      $display("FAIL reset_access_outputs got addr=%h data=%h wr=%b sel=%b en=%b grant=%b rdy=%b want all zero",
        M_PADDR, M_PWDATA, M_PWRITE, M_PSELx, M_PENABLE, GRANT, S_PREADY);
    end
    run_xfer(4'b1111, 0, 16'h0, 1'b0, g);
    checks++;
    if (g !== 0) begin
      failures++;
      $display("FAIL reset_access_next got master %0d want 0", g);
    end
  endtask

  task automatic test_random();
    int g;
    logic [3:0] m;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      m = 4'($urandom_range(1, 15));
      run_xfer(m, $urandom_range(0, 3), 16'h0, 1'b0, g);
    end
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      failures++;
      $display("FAIL no_watchdog got err=%b want 0", TIMEOUT_ERR);
    end
  endtask

  task automatic test_watchdog();
    int pulse_at = -1;
    @(negedge clk);
    w_reset = 1;
    @(negedge clk);
    w_reset = 0;
    w_sel = 4'b0010;
    w_ready = 0;
    w_rdata = 16'hFFFF;
    @(negedge clk);
    w_sel = 0;
    for (int c = 1; c <= 20 && pulse_at < 0; c++) begin
      @(negedge clk);
      #1;
      if (w_spready !== 4'b0) begin
        pulse_at = c;
        checks++;
        if (w_spready !== 4'b0010 || w_sprdata !== 64'b0 || w_err !== 1'b0) begin
          failures++;
          $display("FAIL watchdog_pulse got rdy=%b rdata=%h err=%b want 0010 0 0", w_spready, w_sprdata, w_err);
        end
      end
    end
    checks++;
    if (pulse_at !== 8) begin
      failures++;
      $display("FAIL watchdog_cycles got %0d want 8", pulse_at);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (w_err !== 1'b1 || w_psel !== (c == 1 || c == 2) ) begin
        failures++;
        $display("FAIL watchdog_sticky cycle %0d got err=%b sel=%b want 1 %b", c, w_err, w_psel, (c == 1 || c == 2));
      end
      w_sel = (c == 0) ? 4'b0001 : 4'b0;
      w_ready = 1;
    end
    w_reset = 1;
    @(negedge clk);
    w_reset = 0;
    #1;
    checks++;
    if (w_err !== 1'b0) begin
      failures++;
      $display("FAIL watchdog_clear got err=%b want 0", w_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_contention();
    test_partial_contention();
    test_wait_states();
    test_reset_in_access();
    test_random();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter that shares one APB slave-side bus between `MASTER_PORTS` APB masters (CPU cores, DMA). It sits between the masters and the address-decoding APB interconnect. Each transfer is granted to exactly one master and then re-issued downstream as a clean SETUP/ACCESS sequence. A completion is routed back only to the granted master. An optional watchdog terminates transfers when the slave never asserts ready.

## Interface
- `BUS_WIDTH`, 16, address and data width.
- `MASTER_PORTS`, 4, number of requesting masters (≥2).
- `TIMEOUT_CYCLES`, 0, maximum ACCESS-phase cycles before forced completion; 0 disables the watchdog.
- Clocking: one clock `clk`; `reset` is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `S_PADDR`  in  MASTER_PORTS*BUS_WIDTH  per-master address; master i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- `S_PWRITE`  in  MASTER_PORTS  per-master write flag.
- `S_PSELx`  in  MASTER_PORTS  per-master select; this is the request.
- `S_PENABLE`  in  MASTER_PORTS  per-master enable; not used for arbitration.
- `S_PWDATA`  in  MASTER_PORTS*BUS_WIDTH  per-master write data.
- `S_PRDATA`  out  MASTER_PORTS*BUS_WIDTH  read data; valid only for the granted master, zero elsewhere.
- `S_PREADY`  out  MASTER_PORTS  one-cycle completion pulse to the granted master.
- `M_PADDR`  out  BUS_WIDTH  registered downstream address.
- `M_PWRITE`  out  1  registered downstream write flag.
- `M_PSELx`  out  1  downstream select; the interconnect decodes it further.
- `M_PENABLE`  out  1  downstream enable.
- `M_PWDATA`  out  BUS_WIDTH  registered downstream write data.
- `M_PRDATA`  in  BUS_WIDTH  slave read data.
- `M_PREADY`  in  1  slave ready.
- `GRANT`  out  MASTER_PORTS  one-hot index of the current owner; zero in IDLE.
- `TIMEOUT_ERR`  out  1  sticky flag, set on any watchdog termination; cleared only by reset.

## Operation
- State machine: IDLE → SETUP → ACCESS → IDLE.
- **IDLE**
  - If any `S_PSELx` bit is set, choose the first requester searching upward from `last+1`, wrapping modulo MASTER_PORTS.
  - Capture that master's `S_PADDR`, `S_PWDATA` and `S_PWRITE` into the `M_*` registers.
  - Set `GRANT` and go to SETUP.
  - If no request is present, stay in IDLE.
- **SETUP**
  - `M_PSELx`=1, `M_PENABLE`=0.
  - Always advance to ACCESS after one cycle.
- **ACCESS**
  - `M_PSELx`=1, `M_PENABLE`=1.
  - When `M_PREADY`=1:
    - `S_PREADY[g]`=1 and `S_PRDATA[g]`=`M_PRDATA`, combinationally in the same cycle.
    - `last`←g, clear `GRANT`, go to IDLE.
  - When `M_PREADY`=0: stay in ACCESS and increment the wait counter.
- **Watchdog** (`TIMEOUT_CYCLES`>0)
  - The counter clears on entry to ACCESS.
  - If the counter reaches `TIMEOUT_CYCLES` with `M_PREADY` still 0, complete as normal but force `S_PRDATA[g]`=0.
  - Set `TIMEOUT_ERR` and go to IDLE.
- **Protocol violation:** if the granted master drops `S_PSELx` mid-transfer, the downstream transfer still runs to completion. The `S_PREADY` pulse is still issued and the master ignores it.
- Non-granted masters see `S_PREADY`=0 and `S_PRDATA`=0 at all times. They hold their access phase, which is legal APB wait behaviour.
- The round-robin pointer `last` is `$clog2(MASTER_PORTS)` bits wide. At reset it is MASTER_PORTS-1, so master 0 has the highest priority first.

## Timing
- **Reset values:** state IDLE, `M_PADDR`=0, `M_PWDATA`=0, `M_PWRITE`=0, `M_PSELx`=0, `M_PENABLE`=0, `GRANT`=0, `S_PREADY`=0, `S_PRDATA`=0, `TIMEOUT_ERR`=0, `last`=MASTER_PORTS-1.
- **Reset mid-transfer:** abort immediately. No `S_PREADY` is issued, and all outputs take their reset values the next cycle.
- **Latency:** request sampled in IDLE at cycle N; SETUP at N+1; ACCESS at N+2. With zero wait states, `S_PREADY` pulses at N+2 and the block is back in IDLE at N+3.
- **Throughput:** minimum 3 cycles per transfer, with one mandatory IDLE cycle between transfers.
- The `M_*` address, data and write outputs stay stable from SETUP until completion.
- **Simultaneous events:** a new request arriving in the completion cycle is considered in the following IDLE cycle, using the updated `last`.

## Test plan
- **Single write:** master 1 requests, address 0x0081, data 0x1234, write, `M_PREADY` tied to 1.
  - `M_PADDR`=0x0081 and `M_PSELx`=1 at N+1.
  - `M_PENABLE`=1 at N+2.
  - `S_PREADY`=4'b0010 at N+2.
- **Full contention:** all 4 masters request continuously from reset.
  - Grant order is 0,1,2,3,0,1.
  - `S_PREADY` pulses every 3 cycles.
- **Partial contention:** masters 0 and 2 request with `last`=0.
  - Master 2 is granted first, then master 0.
  - Masters 1 and 3 are never granted.
- **Wait states:** `M_PREADY` low for 3 ACCESS cycles; master 3 reads 0xBEEF.
  - ACCESS lasts 4 cycles.
  - `S_PRDATA` slot 3 = 0xBEEF only in the final cycle.
  - All other slots read 0.
- **Reset in ACCESS:** `reset` pulsed while master 2 is in its access phase.
  - Next cycle, all outputs are zero and no `S_PREADY` is issued.
  - Next grant with all masters requesting is master 0.
- **Watchdog:** `TIMEOUT_CYCLES`=8, `M_PREADY` held at 0.
  - `S_PREADY` pulses after 8 ACCESS cycles with `S_PRDATA`=0.
  - `TIMEOUT_ERR`=1 and stays 1 until reset.
